// File: rtl/rsa_modexp_unit.sv
// Modular exponentiator (plain_text^exp_e mod mod_n): left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier, fixed 2*WIDTH*WIDTH+1 edge latency.
module rsa_modexp_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en_rsa,
   input  logic             rst_rsa,
   input  logic [WIDTH-1:0] plain_text,
   input  logic [WIDTH-1:0] exp_e,
   input  logic [WIDTH-1:0] mod_n,
   output logic             eoc_rsa_unit,
   output logic [WIDTH-1:0] cipher_text,
   output logic             err,
   output logic             busy
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SQUARE, MULT, DONE} state_t;
   typedef struct packed {
      logic [WIDTH-1:0] m;
      logic [WIDTH-1:0] e;
      logic [WIDTH-1:0] n;
   } opnd_t;

   state_t           state_q, state_d;
   opnd_t            op_q, op_d;
   logic [WIDTH-1:0] r_q, r_d, p_q, p_d;
   logic [IW-1:0]    i_q, i_d, j_q, j_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] b_op, mm_res;
   logic [WIDTH+1:0] t_sum, t_1, t_2, n_ext;

   // One interleaved multiply step: A is always R, B is R (square) or M (multiply).
   // P<N and R<N keep T below 3N, so two conditional subtractions fully reduce it.
   always_comb begin
      b_op   = (state_q == MULT) ? op_q.m : r_q;
      n_ext  = {2'b00, op_q.n};
      t_sum  = {1'b0, p_q, 1'b0} + (b_op[j_q] ? {2'b00, r_q} : '0);
      t_1    = (t_sum >= n_ext) ? t_sum - n_ext : t_sum;
      t_2    = (t_1 >= n_ext) ? t_1 - n_ext : t_1;
      mm_res = t_2[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      r_d     = r_q;
      p_d     = p_q;
      i_d     = i_q;
      j_d     = j_q;
      err_d   = err_q;
      if (en_rsa) begin
         case (state_q)
            IDLE: begin
               op_d = '{m: plain_text, e: exp_e, n: mod_n};
               if (mod_n < WIDTH'(2) || plain_text >= mod_n) begin
                  r_d     = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  r_d     = WIDTH'(1);
                  p_d     = '0;
                  i_d     = TOP;
                  j_d     = TOP;
                  state_d = SQUARE;
               end
            end
            SQUARE: begin
               if (j_q == '0) begin
                  r_d     = mm_res;
                  p_d     = '0;
                  j_d     = TOP;
                  state_d = MULT;
               end else begin
                  p_d = mm_res;
                  j_d = j_q - 1'b1;
               end
            end
            MULT: begin
               if (j_q == '0) begin
                  // Multiply always runs; the exponent bit only selects whether it is kept.
                  r_d = op_q.e[i_q] ? mm_res : r_q;
                  if (i_q == '0) begin
                     state_d = DONE;
                  end else begin
                     i_d     = i_q - 1'b1;
                     p_d     = '0;
                     j_d     = TOP;
                     state_d = SQUARE;
                  end
               end else begin
                  p_d = mm_res;
                  j_d = j_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         op_q    <= '0;
         r_q     <= '0;
         p_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         err_q   <= 1'b0;
      end else if (!rst_rsa) begin
         state_q <= IDLE;
         op_q    <= '0;
         r_q     <= '0;
         p_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         r_q     <= r_d;
         p_q     <= p_d;
         i_q     <= i_d;
         j_q     <= j_d;
         err_q   <= err_d;
      end
   end

   assign eoc_rsa_unit = (state_q == DONE);
   assign cipher_text  = eoc_rsa_unit ? r_q : '0;
   assign err          = eoc_rsa_unit & err_q;
   assign busy         = (state_q == SQUARE) || (state_q == MULT);
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Scoreboard bench for rsa_modexp_unit: stimulus pushes expected results, a monitor
// compares them on each rising edge of eoc_rsa_unit.
module tb_rsa_modexp_unit;
   logic       clk = 1'b0;
   logic       rstb, en_rsa, rst_rsa;
   logic [7:0] plain_text, exp_e, mod_n;
   logic       eoc_rsa_unit, err, busy;
   logic [7:0] cipher_text;

   rsa_modexp_unit #(.WIDTH(8)) dut (
      .clk(clk), .rstb(rstb), .en_rsa(en_rsa), .rst_rsa(rst_rsa),
      .plain_text(plain_text), .exp_e(exp_e), .mod_n(mod_n),
      .eoc_rsa_unit(eoc_rsa_unit), .cipher_text(cipher_text),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] c;
      logic       e;
      int         cyc;
      int         bsy;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_pass = 0, n_tot = 0;
   int   bcnt = 0;
   logic eoc_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      n_tot++;
      if (act !== expv) $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      else n_pass++;
   endtask

   // Monitor: samples 2 time units after each posedge.
   initial forever begin
      exp_t x;
      @(posedge clk);
      #2;
      if (!rstb || !rst_rsa) bcnt = 0;
      else if (busy) bcnt++;
      if (eoc_rsa_unit && !eoc_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_eoc", 1, 0);
         end else begin
            x = exp_q.pop_front();
            chk("cipher_text", int'(cipher_text), int'(x.c));
            chk("err", int'(err), int'(x.e));
            chk("eoc_edge", cyc, x.cyc);
            chk("busy_edges", bcnt, x.bsy);
         end
      end
      eoc_prev = eoc_rsa_unit;
   end

   // Soft reset, present operands for the latch edge, then scramble them.
   task automatic launch(input logic [7:0] m, e, n, c, input logic er,
                         input int lat, input int bsy);
      @(negedge clk);
      rst_rsa = 1'b0;
      en_rsa  = 1'b1;
      @(negedge clk);
      plain_text = m;
      exp_e      = e;
      mod_n      = n;
      rst_rsa    = 1'b1;
      exp_q.push_back('{c, er, cyc + lat, bsy});
      @(negedge clk);
      plain_text = ~m;
      exp_e      = ~e;
      mod_n      = n ^ 8'h5a;
   endtask

   task automatic wait_eoc(input int maxc);
      int k;
      k = 0;
      while (!eoc_rsa_unit && k < maxc) begin
         @(negedge clk);
         k++;
      end
      if (!eoc_rsa_unit) chk("eoc_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      rstb = 1'b0; en_rsa = 1'b0; rst_rsa = 1'b0;
      plain_text = '0; exp_e = '0; mod_n = '0;
      #17;
      chk("rst_eoc", int'(eoc_rsa_unit), 0);
      chk("rst_cipher", int'(cipher_text), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      rstb = 1'b1;

      launch(8'd88, 8'd7, 8'd187, 8'd11, 1'b0, 129, 128);  wait_eoc(300);
      launch(8'd11, 8'd23, 8'd187, 8'd88, 1'b0, 129, 128); wait_eoc(300);
      launch(8'd5, 8'd0, 8'd187, 8'd1, 1'b0, 129, 128);    wait_eoc(300);
      launch(8'd0, 8'd9, 8'd187, 8'd0, 1'b0, 129, 128);    wait_eoc(300);

      // Freeze for 10 edges inside the first SQUARE (edges 5..14).
      launch(8'd88, 8'd7, 8'd187, 8'd11, 1'b0, 139, 138);
      repeat (3) @(negedge clk);
      en_rsa = 1'b0;
      repeat (10) @(negedge clk);
      en_rsa = 1'b1;
      wait_eoc(300);

      launch(8'd200, 8'd7, 8'd187, 8'd0, 1'b1, 1, 0); wait_eoc(10);
      launch(8'd0, 8'd7, 8'd1, 8'd0, 1'b1, 1, 0);     wait_eoc(10);
      launch(8'd0, 8'd7, 8'd0, 8'd0, 1'b1, 1, 0);     wait_eoc(10);

      // Abort during MULT (edge 13 applies the soft reset).
      launch(8'd88, 8'd7, 8'd187, 8'd11, 1'b0, 129, 128);
      repeat (11) @(negedge clk);
      rst_rsa = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_eoc", int'(eoc_rsa_unit), 0);
      chk("abort_cipher", int'(cipher_text), 0);
      chk("abort_busy", int'(busy), 0);
      exp_q.delete();
      launch(8'd2, 8'd3, 8'd187, 8'd8, 1'b0, 129, 128); wait_eoc(300);

      // DONE holds while inputs and enable wander.
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         plain_text = 8'($urandom);
         exp_e      = 8'($urandom);
         mod_n      = 8'($urandom);
         en_rsa     = 1'($urandom);
         @(posedge clk);
         #2;
         chk("hold_eoc", int'(eoc_rsa_unit), 1);
         chk("hold_cipher", int'(cipher_text), 8);
      end

      @(negedge clk);
      #3;
      rstb = 1'b0;
      #1;
      chk("async_eoc", int'(eoc_rsa_unit), 0);
      chk("async_cipher", int'(cipher_text), 0);
      chk("async_busy", int'(busy), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/rsa_modexp_unit.md
Name: rsa_modexp_unit

Overview:
- Responder side of the RSA enable/soft-reset/end-of-conversion handshake. The enable FSM drives en_rsa and rst_rsa into this block; this block returns eoc_rsa_unit.
- Computes cipher_text = plain_text^exp_e mod mod_n.
- Algorithm: left-to-right square-and-multiply, built on a bit-serial interleaved modular multiplier.
- Latency is fixed and independent of operand values.

Parameters:
WIDTH, 8, operand width in bits for plain_text, exp_e, mod_n and cipher_text.

Ports:
clk  input  1  system clock; all state updates on posedge.
rstb  input  1  asynchronous active-low reset.
en_rsa  input  1  enable; when 0, all state freezes except soft reset.
rst_rsa  input  1  synchronous active-low soft reset; 1 = run.
plain_text  input  WIDTH  message M; sampled only at the latch edge.
exp_e  input  WIDTH  exponent E; sampled only at the latch edge.
mod_n  input  WIDTH  modulus N; sampled only at the latch edge.
eoc_rsa_unit  output  1  end of conversion; level signal, held until soft reset.
cipher_text  output  WIDTH  result; valid while eoc_rsa_unit=1, else 0.
err  output  1  invalid operands detected; valid while eoc_rsa_unit=1.
busy  output  1  high in SQUARE and MULT.

Behaviour:
- Reset values (rstb=0, asynchronous): state=IDLE, eoc_rsa_unit=0, cipher_text=0, err=0, busy=0, all internal registers 0.
- Soft reset: at any posedge with rst_rsa=0, regardless of en_rsa, apply the same values as rstb. Soft reset has priority over all transitions, including mid-operation.
- Advancing edge: a posedge with rst_rsa=1 and en_rsa=1. Edges with en_rsa=0 hold every register and output.
- Internal registers: M, E, N, accumulator R, product P, operand index i (exponent bit), cycle index j (multiplier bit).
- State machine (all transitions on advancing edges):
  - IDLE → latch M, E, N. If N<2 or M>=N: go to DONE with R=0 and err=1. Otherwise R=1, i=WIDTH-1, P=0, j=WIDTH-1, go to SQUARE.
  - SQUARE: compute P=R*R mod N over WIDTH edges. On the edge with j=0: R<=result, P<=0, j<=WIDTH-1, go to MULT.
  - MULT: compute P=R*M mod N over WIDTH edges. On the edge with j=0: R<=(E[i] ? result : R).
    - If i=0 go to DONE.
    - Else i<=i-1, P<=0, j<=WIDTH-1, go to SQUARE.
  - DONE: eoc_rsa_unit=1, cipher_text=R, err as set at latch. DONE has no exit except soft reset or rstb.
- The multiply is always performed, even when E[i]=0, to keep latency constant.
- Modular multiply step, per edge, for A*B mod N:
  - T = 2*P + (B[j] ? A : 0), evaluated at WIDTH+2 bits.
  - If T>=N, subtract N. If still T>=N, subtract N again.
  - P<=T; j<=j-1.
  - Invariants: P<N and A<N, so T<3N and the result is <N.
- Latency:
  - Counting the latch edge as edge 1, edge 2*WIDTH*WIDTH+1 enters DONE. WIDTH=8 gives 129 edges.
  - The invalid-operand path enters DONE on edge 1.
  - Edges with en_rsa=0 do not count.
- Outputs are registered and update on the edge that enters DONE. busy=1 exactly while in SQUARE or MULT.
- Operand inputs changing after the latch edge have no effect.
- E=0 with valid operands gives cipher_text=1.
- Simultaneous soft reset and DONE entry: soft reset wins and eoc stays 0.

Test Plan:
1. WIDTH=8, N=187, E=7, M=88; rst_rsa 0→1 with en_rsa=1 → eoc_rsa_unit rises on edge 129 after the latch edge; cipher_text=11, err=0; busy high for exactly 128 edges.
2. N=187, E=23, M=11 → cipher_text=88 at edge 129. Then E=0, M=5 → cipher_text=1. Then M=0, E=9 → cipher_text=0.
3. Case 1 with en_rsa=0 for 10 edges mid-SQUARE → all registers frozen; eoc at edge 139; cipher_text=11.
4. rst_rsa=0 for one edge during MULT of case 1 → eoc=0, cipher_text=0, state IDLE. Re-release with N=187, E=3, M=2 → cipher_text=8 after 129 edges.
5. Invalid operands: M=200 with N=187; then N=1; then N=0 → each enters DONE on the latch edge with eoc=1, err=1, cipher_text=0.
6. Hold DONE for 50 edges, toggling inputs → eoc_rsa_unit and cipher_text stable. Then assert rstb asynchronously mid-cycle → outputs go to 0 immediately.
